// File: rtl/uart_tx_sched.sv
// uart_tx_sched: transmit-side scheduler for the UART.
// Two byte producers (CPU and loopback) share the single write port of the
// TX FIFO through a round-robin arbiter, and a small drain FSM moves bytes
// from the FIFO into the transmit engine over a start/busy handshake.
// The FIFO gives writes priority over reads, so the write slot is closed in
// the one cycle where this block pops; otherwise the pop would be lost.

module uart_tx_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             req0_valid_i,
    input  logic [WIDTH-1:0] req0_data_i,
    output logic             req0_ready_o,

    input  logic             req1_valid_i,
    input  logic [WIDTH-1:0] req1_data_i,
    output logic             req1_ready_o,

    output logic             fifo_we_o,
    output logic [WIDTH-1:0] fifo_wdata_o,
    output logic             fifo_re_o,
    input  logic [WIDTH-1:0] fifo_rdata_i,
    input  logic             fifo_full_i,
    input  logic             fifo_empty_i,

    input  logic             tx_en_i,
    input  logic             tx_busy_i,
    output logic             tx_start_o,
    output logic [WIDTH-1:0] tx_data_o,
    output logic             sent_o
);

    // Drain FSM encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_POP   = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_START = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic             sent_q, sent_d;
    logic             last_grant_q, last_grant_d;

    logic             write_slot;
    logic             grant0;
    logic             grant1;
    logic             write_fire;

    // Round-robin write arbitration; producer 1 wins only when it is alone or
    // producer 0 was the last one written. No write is accepted while the
    // block is held in reset or while the drain FSM is popping.
    always_comb begin
        write_slot   = (state_q != ST_POP) && !fifo_full_i && !rst_i;
        grant1       = req1_valid_i && (!req0_valid_i || !last_grant_q);
        grant0       = req0_valid_i && !grant1;
        req0_ready_o = grant0 && write_slot;
        req1_ready_o = grant1 && write_slot;
        write_fire   = (req0_valid_i && req0_ready_o) || (req1_valid_i && req1_ready_o);
        fifo_we_o    = write_fire;
        fifo_wdata_o = '0;
        if (write_fire) begin
            fifo_wdata_o = grant1 ? req1_data_i : req0_data_i;
        end
        last_grant_d = write_fire ? grant1 : last_grant_q;
    end

    // Drain FSM next state, transmit byte capture and accept pulse
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        sent_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_en_i && !fifo_empty_i && !tx_busy_i) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                tx_data_d = fifo_rdata_i;
                state_d   = ST_START;
            end
            ST_START: begin
                if (tx_busy_i) begin
                    state_d = ST_DRAIN;
                    sent_d  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!tx_busy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops the pending byte and the start request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            tx_data_q    <= '0;
            sent_q       <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            sent_q       <= sent_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Output decode from the registered state
    always_comb begin
        fifo_re_o  = (state_q == ST_POP);
        tx_start_o = (state_q == ST_START);
        tx_data_o  = tx_data_q;
        sent_o     = sent_q;
    end

endmodule
